distributor14: RTL and testbench

DISTRIBUTOR14 -- requirements
Module: distributor14

---
 rtl/distributor14.sv | 93 +++++++++
 tb/tb_distributor14.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/distributor14.sv
// distributor14: routes a 4-bit word into one of four holding registers with per-channel
// full flags, consume strobes and a saturating stall counter. DISTRIBUTOR_AUTO_SEL_EN adds round-robin targeting.
module distributor14 (
  input  logic       iClk,
  input  logic       iRst,
  input  logic [3:0] iD,
  input  logic       iS1,
  input  logic       iS0,
  input  logic       iValid,
  output logic       oReady,
  input  logic [3:0] iAck,
  output logic [3:0] oZ0,
  output logic [3:0] oZ1,
  output logic [3:0] oZ2,
  output logic [3:0] oZ3,
  output logic [3:0] oV,
  output logic [7:0] oStall
`ifdef DISTRIBUTOR_AUTO_SEL_EN
  ,
  input  logic       iAuto,
  output logic [1:0] oPtr
`endif
);

  logic [3:0] z_q [4];
  logic [3:0] v_q;
  logic [7:0] stall_q;
  logic [1:0] tgt;
  logic       accept;

`ifdef DISTRIBUTOR_AUTO_SEL_EN
  logic [1:0] ptr_q;

  always_comb begin
    tgt = iAuto ? ptr_q : {iS1, iS0};
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      ptr_q <= '0;
    end else if (accept && iAuto) begin
      ptr_q <= ptr_q + 2'd1;
    end
  end

  assign oPtr = ptr_q;
`else
  always_comb begin
    tgt = {iS1, iS0};
  end
`endif

  // A full target can still take a word when it is being drained this same cycle.
  assign oReady = ~v_q[tgt] | iAck[tgt];
  assign accept = iValid & oReady;

  // NOTE: the holding registers are few and visible on ports, so they are reset
  // like ordinary flops instead of being left as an unreset memory.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      for (int n = 0; n < 4; n++) begin
        z_q[n] <= '0;
      end
      v_q <= '0;
    end else begin
      for (int n = 0; n < 4; n++) begin
        // NOTE: non-blocking updates keep every channel reading pre-edge state.
        if (accept && (tgt == 2'(n))) begin
          z_q[n] <= iD;
          v_q[n] <= 1'b1;
        end else if (iAck[n]) begin
          v_q[n] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      stall_q <= '0;
    end else if (iValid && !oReady && (stall_q != 8'hFF)) begin
      stall_q <= stall_q + 8'd1;
    end
  end

  assign oZ0    = z_q[0];
  assign oZ1    = z_q[1];
  assign oZ2    = z_q[2];
  assign oZ3    = z_q[3];
  assign oV     = v_q;
  assign oStall = stall_q;

endmodule

// File: tb/tb_distributor14.sv
// Self-checking bench for distributor14: vector table plus scoreboarded reference model
// and hand-written stall, reset and (with DISTRIBUTOR_AUTO_SEL_EN) round-robin sequences.
`timescale 1ns/1ps
module tb_distributor14;

  logic       iClk = 1'b0;
  logic       iRst;
  logic [3:0] iD;
  logic       iS1, iS0;
  logic       iValid;
  logic       oReady;
  logic [3:0] iAck;
  logic [3:0] oZ0, oZ1, oZ2, oZ3;
  logic [3:0] oV;
  logic [7:0] oStall;
`ifdef DISTRIBUTOR_AUTO_SEL_EN
  logic       iAuto;
  logic [1:0] oPtr;
`endif

  distributor14 dut (
    .iClk(iClk), .iRst(iRst), .iD(iD), .iS1(iS1), .iS0(iS0),
    .iValid(iValid), .oReady(oReady), .iAck(iAck),
    .oZ0(oZ0), .oZ1(oZ1), .oZ2(oZ2), .oZ3(oZ3), .oV(oV), .oStall(oStall)
`ifdef DISTRIBUTOR_AUTO_SEL_EN
    , .iAuto(iAuto), .oPtr(oPtr)
`endif
  );

  always #5 iClk = ~iClk;

  typedef struct packed {
    logic [3:0][3:0] z;
    logic [3:0]      v;
    logic [7:0]      stall;
    logic [1:0]      ptr;
  } state_t;

  typedef struct {
    logic [3:0] d;
    logic [1:0] s;
    logic       valid;
    logic [3:0] ack;
    logic       exp_ready;
    logic [3:0] exp_v;
    logic [7:0] exp_stall;
  } vec_t;

  state_t m;
  state_t sb[$];
  vec_t   vecs[8];
  int     n_cmp = 0;
  int     n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m = '0;
    sb.delete();
  endtask

  // Drive one cycle from posedge+1, check oReady, predict, then compare after the edge.
  task automatic drive_cycle(input logic [3:0] d, input logic [1:0] s, input logic valid,
                             input logic [3:0] ack, input logic auto_sel);
    logic [1:0] t;
    logic       rdy, acc;
    state_t     e;
    iD = d; {iS1, iS0} = s; iValid = valid; iAck = ack;
`ifdef DISTRIBUTOR_AUTO_SEL_EN
    iAuto = auto_sel;
    t = auto_sel ? m.ptr : s;
`else
    t = s;
`endif
    #1;
    rdy = ~m.v[t] | ack[t];
    check("ready", {31'd0, oReady}, {31'd0, rdy});
    acc = valid & rdy;
    for (int n = 0; n < 4; n++) begin
      if (acc && t == 2'(n)) begin
        m.z[n] = d;
        m.v[n] = 1'b1;
      end else if (ack[n]) begin
        m.v[n] = 1'b0;
      end
    end
    if (valid && !rdy && m.stall != 8'hFF) m.stall = m.stall + 8'd1;
    if (acc && auto_sel) m.ptr = m.ptr + 2'd1;
    sb.push_back(m);
    @(posedge iClk);
    #1;
    e = sb.pop_front();
    check("z0", {28'd0, oZ0}, {28'd0, e.z[0]});
    check("z1", {28'd0, oZ1}, {28'd0, e.z[1]});
    check("z2", {28'd0, oZ2}, {28'd0, e.z[2]});
    check("z3", {28'd0, oZ3}, {28'd0, e.z[3]});
    check("v", {28'd0, oV}, {28'd0, e.v});
    check("stall", {24'd0, oStall}, {24'd0, e.stall});
`ifdef DISTRIBUTOR_AUTO_SEL_EN
    check("ptr", {30'd0, oPtr}, {30'd0, e.ptr});
`endif
  endtask

  // Short reset pulse between edges; returns aligned at posedge+1.
  task automatic do_reset();
    iValid = 1'b0; iAck = '0;
    #1 iRst = 1'b1;
    #1 iRst = 1'b0;
    model_reset();
    @(posedge iClk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{4'hA, 2'd2, 1'b1, 4'b0000, 1'b1, 4'b0100, 8'd0};
    vecs[1] = '{4'h5, 2'd1, 1'b1, 4'b0000, 1'b1, 4'b0110, 8'd0};
    vecs[2] = '{4'h6, 2'd2, 1'b1, 4'b0000, 1'b0, 4'b0110, 8'd1};
    vecs[3] = '{4'h6, 2'd2, 1'b1, 4'b0100, 1'b1, 4'b0110, 8'd1};
    vecs[4] = '{4'h3, 2'd0, 1'b1, 4'b0010, 1'b1, 4'b0101, 8'd1};
    vecs[5] = '{4'h7, 2'd0, 1'b1, 4'b0001, 1'b1, 4'b0101, 8'd1};
    vecs[6] = '{4'h9, 2'd3, 1'b0, 4'b1000, 1'b1, 4'b0101, 8'd1};
    vecs[7] = '{4'h9, 2'd3, 1'b0, 4'b0101, 1'b1, 4'b0000, 8'd1};

    iRst = 1'b1; iD = '0; iS1 = 1'b0; iS0 = 1'b0; iValid = 1'b0; iAck = '0;
`ifdef DISTRIBUTOR_AUTO_SEL_EN
    iAuto = 1'b0;
`endif
    #12;
    iRst = 1'b0;
    model_reset();
    check("rst_v", {28'd0, oV}, 32'd0);
    check("rst_stall", {24'd0, oStall}, 32'd0);
    check("rst_z", {16'd0, oZ0, oZ1, oZ2, oZ3}, 32'd0);
    @(posedge iClk);
    #1;

    // Vector table; hand expectations on top of the scoreboard.
    for (int i = 0; i < 8; i++) begin
      drive_cycle(vecs[i].d, vecs[i].s, vecs[i].valid, vecs[i].ack, 1'b0);
      check("vec_ready", {31'd0, oReady === oReady}, 32'd1);
      check("vec_v", {28'd0, oV}, {28'd0, vecs[i].exp_v});
      check("vec_stall", {24'd0, oStall}, {24'd0, vecs[i].exp_stall});
      if (i == 0) check("vec0_z2", {28'd0, oZ2}, 32'hA);
      if (i == 5) check("vec5_z0", {28'd0, oZ0}, 32'h7);
    end
    check("retain_z0", {28'd0, oZ0}, 32'h7);

    // Stall for 5 cycles, then drain in the same cycle as the accept.
    do_reset();
    drive_cycle(4'h4, 2'd1, 1'b1, 4'b0000, 1'b0);
    for (int i = 0; i < 5; i++) drive_cycle(4'h8, 2'd1, 1'b1, 4'b0000, 1'b0);
    check("stall5", {24'd0, oStall}, 32'd5);
    check("stall_z1_held", {28'd0, oZ1}, 32'h4);
    drive_cycle(4'h8, 2'd1, 1'b1, 4'b0010, 1'b0);
    check("drain_v1", {31'd0, oV[1]}, 32'd1);
    check("drain_z1", {28'd0, oZ1}, 32'h8);

    // 300 more stall cycles saturate the counter.
    for (int i = 0; i < 300; i++) drive_cycle(4'h9, 2'd1, 1'b1, 4'b0000, 1'b0);
    check("stall_sat", {24'd0, oStall}, 32'd255);

    // Asynchronous reset between edges with all channels full.
    do_reset();
    for (int i = 0; i < 4; i++) drive_cycle(4'(i + 1), 2'(i), 1'b1, 4'b0000, 1'b0);
    check("full_v", {28'd0, oV}, 32'hF);
    iValid = 1'b0; iAck = '0;
    #1 iRst = 1'b1;
    #1;
    check("async_v", {28'd0, oV}, 32'd0);
    check("async_z", {16'd0, oZ0, oZ1, oZ2, oZ3}, 32'd0);
    check("async_stall", {24'd0, oStall}, 32'd0);
    iRst = 1'b0;
    model_reset();
    @(posedge iClk);
    #1;

    // Reset across an edge with an accept pending, then a fresh accept.
    iD = 4'hF; {iS1, iS0} = 2'd3; iValid = 1'b1; iAck = '0;
    #1 iRst = 1'b1;
    @(posedge iClk);
    #1 iRst = 1'b0;
    model_reset();
    check("inflight_v", {28'd0, oV}, 32'd0);
    check("inflight_z3", {28'd0, oZ3}, 32'd0);
    iValid = 1'b0;
    for (int s = 0; s < 4; s++) begin
      {iS1, iS0} = 2'(s);
      #0.5;
      check("post_rst_ready", {31'd0, oReady}, 32'd1);
    end
    drive_cycle(4'h2, 2'd1, 1'b1, 4'b0000, 1'b0);
    check("first_accept_v", {28'd0, oV}, 32'b0010);

`ifdef DISTRIBUTOR_AUTO_SEL_EN
    // Round-robin: words 1..5 land in channels 0,1,2,3,0.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      check("rr_ptr_before", {30'd0, oPtr}, 32'(i % 4));
      drive_cycle(4'(i + 1), 2'd2, 1'b1, 4'hF, 1'b1);
      check("rr_v", {28'd0, oV}, 32'(1 << (i % 4)));
    end
    check("rr_ptr_end", {30'd0, oPtr}, 32'd1);
    check("rr_z0", {28'd0, oZ0}, 32'd5);
    drive_cycle(4'h6, 2'd2, 1'b1, 4'hF, 1'b0);
    check("rr_ptr_hold", {30'd0, oPtr}, 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
